// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//   Addressed write request bus from the writeback arbiter to the host
//   write/DMA path. Uses a valid/ready handshake.
//   master : arbiter side (drives the request, samples ready)
//   slave  : sink side (samples the request, drives ready)
//   wb_valid_o  request valid
//   wb_ready_i  request accepted by the sink
//   wb_addr_o   target address
//   wb_data_o   value being written
//   wb_id_o     source channel index
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [ID_WIDTH-1:0]   wb_id_o;

  modport master (
    output wb_valid_o,
    output wb_addr_o,
    output wb_data_o,
    output wb_id_o,
    input  wb_ready_i
  );

  modport slave (
    input  wb_valid_o,
    input  wb_addr_o,
    input  wb_data_o,
    input  wb_id_o,
    output wb_ready_i
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Destination-side consumer of per-register writeback streams in the host
//   clock domain. Each channel has a coalescing slot that keeps only the
//   latest value. Pending slots are served round-robin. One addressed write
//   is issued at a time over the wb interface.
//
//   clk_i            clock
//   rstn_i           async active-low reset
//   wb_en_i          1 = issuing allowed, 0 = hold (slots still capture)
//   ch_valid_i       per-channel new-value strobe
//   ch_data_i        per-channel value, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready_o       per-channel accept, 1 whenever out of reset
//   wb               write request bus (master side)
//   pending_o        per-slot pending flags
//   overwrite_cnt_o  saturating count of values replaced before issue
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no request outstanding; may pick a pending slot this cycle
//   SEND  | request on the bus, held until wb_ready_i
module writeback_arbiter #(
  parameter int                    NUM_CH      = 10,
  parameter int                    DATA_WIDTH  = 40,
  parameter int                    ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    ADDR_STRIDE = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         wb_en_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  output logic [NUM_CH-1:0]            ch_ready_o,
  writeback_arbiter_if.master          wb,
  output logic [NUM_CH-1:0]            pending_o,
  output logic [31:0]                  overwrite_cnt_o
);

  localparam int ID_W = $clog2(NUM_CH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       next_ptr;
  logic                  found;
  logic                  issue_now;
  logic                  ready_q;
  logic [NUM_CH-1:0]     pending_q;
  logic [NUM_CH-1:0]     ovr_hit;
  logic [31:0]           ovr_cnt;
  logic [32:0]           cnt_sum;
  logic [DATA_WIDTH-1:0] slot_data [NUM_CH];

  // First pending slot at or after the RR pointer, wrapping past NUM_CH-1.
  always_comb begin : arb_pick
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pending_q[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign issue_now = (state == ST_IDLE) && wb_en_i && found;
  assign next_ptr  = (winner == ID_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

  // A capture onto a pending slot loses the older value, unless that slot is
  // being issued in the same cycle: then the old value goes out and the new
  // one simply becomes the next pending value.
  always_comb begin
    ovr_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ovr_hit[k] = ch_valid_i[k] && pending_q[k] && !(issue_now && (winner == ID_W'(k)));
    end
  end

  assign cnt_sum = {1'b0, ovr_cnt} + 33'($countones(ovr_hit));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      ready_q       <= 1'b0;
      pending_q     <= '0;
      ovr_cnt       <= '0;
      wb.wb_valid_o <= 1'b0;
      wb.wb_addr_o  <= '0;
      wb.wb_data_o  <= '0;
      wb.wb_id_o    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        slot_data[k] <= '0;
      end
    end else begin
      ready_q <= 1'b1;

      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_valid_i[k]) begin
          slot_data[k] <= ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          pending_q[k] <= 1'b1;
        end else if (issue_now && (winner == ID_W'(k))) begin
          pending_q[k] <= 1'b0;
        end
      end

      ovr_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];

      case (state)
        ST_IDLE: begin
          if (issue_now) begin
            wb.wb_valid_o <= 1'b1;
            wb.wb_data_o  <= slot_data[winner];
            wb.wb_id_o    <= winner;
            wb.wb_addr_o  <= BASE_ADDR + ADDR_WIDTH'(winner) * ADDR_WIDTH'(ADDR_STRIDE);
            rr_ptr        <= next_ptr;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          // wb_en_i is ignored here: an issued request is never withdrawn.
          if (wb.wb_ready_i) begin
            wb.wb_valid_o <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ch_ready_o      = {NUM_CH{ready_q}};
  assign pending_o       = pending_q;
  assign overwrite_cnt_o = ovr_cnt;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int          NUM_CH = 10;
  localparam int          DW     = 40;
  localparam int          AW     = 64;
  localparam int          IDW    = 4;
  localparam logic [63:0] BASE   = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam int          STRIDE = 8;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  logic                  clk;
  logic                  rstn;
  logic                  wb_en;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH*DW-1:0]  ch_data;
  logic [NUM_CH-1:0]     ch_ready;
  logic [NUM_CH-1:0]     pending;
  logic [31:0]           ovr_cnt;

  writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) wbif ();

  writeback_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .wb_en_i(wb_en),
    .ch_valid_i(ch_valid),
    .ch_data_i(ch_data),
    .ch_ready_o(ch_ready),
    .wb(wbif.master),
    .pending_o(pending),
    .overwrite_cnt_o(ovr_cnt)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   wr_count  = 0;
  int   exp_ovr   = 0;
  exp_t exp_q[$];
  int   hs_q[$];
  exp_t e;
  logic [63:0] exp_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Handshake monitor: valid && ready at the negedge means the write is
  // accepted on the following posedge.
  always @(negedge clk) begin
    if (rstn && wbif.wb_valid_o && wbif.wb_ready_i) begin
      wr_count++;
      hs_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write id=%0d data=%h", wbif.wb_id_o, wbif.wb_data_o);
      end else begin
        e        = exp_q.pop_front();
        exp_addr = BASE + 64'(e.id) * 64'(STRIDE);
        if (wbif.wb_id_o !== e.id || wbif.wb_data_o !== e.data || wbif.wb_addr_o !== exp_addr) begin
          failures++;
          $display("FAIL write_content got id=%0d data=%h addr=%h exp id=%0d data=%h addr=%h",
                   wbif.wb_id_o, wbif.wb_data_o, wbif.wb_addr_o, e.id, e.data, exp_addr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    ch_valid[ch]          = 1'b1;
    ch_data[ch*DW +: DW]  = d;
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    exp_t x;
    x.id   = IDW'(ch);
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wbif.wb_valid_o) && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || wbif.wb_valid_o) begin
      failures++;
      $display("FAIL drain_timeout left=%0d valid=%b", exp_q.size(), wbif.wb_valid_o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; wb_en = 1'b0; wbif.wb_ready_i = 1'b0;
    ch_valid = '0; ch_data = '0;
    step(); step();
    checks++;
    if (wbif.wb_valid_o !== 1'b0 || pending !== '0 || ovr_cnt !== 32'd0 || ch_ready !== '0 ||
        wbif.wb_addr_o !== '0 || wbif.wb_data_o !== '0 || wbif.wb_id_o !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%b pending=%b cnt=%0d ready=%b addr=%h data=%h id=%0d exp all 0",
               wbif.wb_valid_o, pending, ovr_cnt, ch_ready, wbif.wb_addr_o, wbif.wb_data_o, wbif.wb_id_o);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (ch_ready !== {NUM_CH{1'b1}}) begin
      failures++;
      $display("FAIL ch_ready_after_reset got=%b exp=%b", ch_ready, {NUM_CH{1'b1}});
    end
  endtask

  task automatic test_rr();
    int h0;
    wb_en = 1'b1; wbif.wb_ready_i = 1'b1;
    h0 = hs_q.size();
    set_ch(0, 40'h00_0000_0A00); set_ch(5, 40'h00_0000_0A05); set_ch(9, 40'h00_0000_0A09);
    push_exp(0, 40'h00_0000_0A00); push_exp(5, 40'h00_0000_0A05); push_exp(9, 40'h00_0000_0A09);
    step();
    ch_valid = '0;
    wait_drain(20);
    checks++;
    if (hs_q.size() != h0 + 3 || hs_q[h0+1] - hs_q[h0] != 2 || hs_q[h0+2] - hs_q[h0+1] != 2) begin
      failures++;
      $display("FAIL rr_spacing got handshakes=%0d exp 3 spaced by 2", hs_q.size() - h0);
    end
    set_ch(0, 40'h00_0000_0B00); set_ch(9, 40'h00_0000_0B09);
    push_exp(0, 40'h00_0000_0B00); push_exp(9, 40'h00_0000_0B09);
    step();
    ch_valid = '0;
    wait_drain(20);
  endtask

  task automatic test_single();
    int w0;
    w0 = wr_count;
    set_ch(3, 40'h12_3456_789A);
    push_exp(3, 40'h12_3456_789A);
    step();
    ch_valid = '0;
    checks++;
    if (wbif.wb_valid_o !== 1'b0 || pending !== 10'b00_0000_1000) begin
      failures++;
      $display("FAIL single_capture valid=%b pending=%b exp valid=0 pending=0000001000",
               wbif.wb_valid_o, pending);
    end
    step();
    checks++;
    if (wbif.wb_valid_o !== 1'b1 || pending !== '0) begin
      failures++;
      $display("FAIL single_latency valid=%b pending=%b exp valid=1 pending=0", wbif.wb_valid_o, pending);
    end
    step(); step();
    checks++;
    if (wr_count - w0 != 1 || wbif.wb_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_done writes=%0d valid=%b exp writes=1 valid=0", wr_count - w0, wbif.wb_valid_o);
    end
  endtask

  task automatic test_coalesce();
    int w0;
    wb_en = 1'b0;
    set_ch(2, 40'd1); step();
    set_ch(2, 40'd2); step();
    set_ch(2, 40'd3); step();
    ch_valid = '0;
    exp_ovr += 2;
    checks++;
    if (ovr_cnt !== 32'(exp_ovr) || wbif.wb_valid_o !== 1'b0 || pending !== 10'b00_0000_0100) begin
      failures++;
      $display("FAIL coalesce_hold cnt=%0d valid=%b pending=%b exp cnt=%0d valid=0 pending=0000000100",
               ovr_cnt, wbif.wb_valid_o, pending, exp_ovr);
    end
    w0 = wr_count;
    push_exp(2, 40'd3);
    wb_en = 1'b1;
    wait_drain(10);
    step(); step();
    checks++;
    if (wr_count - w0 != 1) begin
      failures++;
      $display("FAIL coalesce_writes got=%0d exp=1", wr_count - w0);
    end
  endtask

  task automatic test_multi_overwrite();
    wb_en = 1'b0;
    set_ch(5, 40'h55_0000_0001); set_ch(6, 40'h66_0000_0001); step();
    set_ch(5, 40'h55_0000_0002); set_ch(6, 40'h66_0000_0002); step();
    ch_valid = '0;
    exp_ovr += 2;
    checks++;
    if (ovr_cnt !== 32'(exp_ovr)) begin
      failures++;
      $display("FAIL multi_overwrite cnt got=%0d exp=%0d", ovr_cnt, exp_ovr);
    end
    push_exp(5, 40'h55_0000_0002); push_exp(6, 40'h66_0000_0002);
    wb_en = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [63:0]   a;
    d = 40'h77_0000_0007;
    a = BASE + 64'(7 * STRIDE);
    wbif.wb_ready_i = 1'b0; wb_en = 1'b1;
    set_ch(7, d); push_exp(7, d);
    step();
    ch_valid = '0;
    step();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin set_ch(1, 40'h11_0000_0001); push_exp(1, 40'h11_0000_0001); end
      if (i == 6) ch_valid = '0;
      if (i == 10) wb_en = 1'b0;
      if (i == 15) wb_en = 1'b1;
      checks++;
      if (wbif.wb_valid_o !== 1'b1 || wbif.wb_id_o !== 4'd7 || wbif.wb_data_o !== d || wbif.wb_addr_o !== a) begin
        failures++;
        $display("FAIL stall_stable cyc=%0d valid=%b id=%0d data=%h addr=%h exp 1/7/%h/%h",
                 i, wbif.wb_valid_o, wbif.wb_id_o, wbif.wb_data_o, wbif.wb_addr_o, d, a);
      end
      step();
    end
    checks++;
    if (pending !== 10'b00_0000_0010) begin
      failures++;
      $display("FAIL stall_queued pending got=%b exp=0000000010", pending);
    end
    wbif.wb_ready_i = 1'b1;
    wait_drain(20);
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("FAIL stall_after pending got=%b exp=0", pending);
    end
  endtask

  task automatic test_issue_capture();
    wb_en = 1'b0; wbif.wb_ready_i = 1'b1;
    set_ch(4, 40'h11);
    step();
    push_exp(4, 40'h11); push_exp(4, 40'hAB);
    wb_en = 1'b1;
    set_ch(4, 40'hAB);
    step();
    ch_valid = '0;
    checks++;
    if (pending[4] !== 1'b1 || ovr_cnt !== 32'(exp_ovr) || wbif.wb_valid_o !== 1'b1 || wbif.wb_data_o !== 40'h11) begin
      failures++;
      $display("FAIL issue_capture pend4=%b cnt=%0d valid=%b data=%h exp 1/%0d/1/11",
               pending[4], ovr_cnt, wbif.wb_valid_o, wbif.wb_data_o, exp_ovr);
    end
    wait_drain(20);
    checks++;
    if (ovr_cnt !== 32'(exp_ovr) || pending !== '0) begin
      failures++;
      $display("FAIL issue_capture_end cnt=%0d pending=%b exp cnt=%0d pending=0", ovr_cnt, pending, exp_ovr);
    end
  endtask

  task automatic test_reset_in_send();
    int w0;
    wbif.wb_ready_i = 1'b0; wb_en = 1'b1;
    set_ch(6, 40'h66); push_exp(6, 40'h66);
    step();
    ch_valid = '0;
    set_ch(8, 40'h81); step();
    set_ch(8, 40'h82); step();
    ch_valid = '0;
    exp_ovr += 1;
    checks++;
    if (wbif.wb_valid_o !== 1'b1 || ovr_cnt !== 32'(exp_ovr)) begin
      failures++;
      $display("FAIL send_before_reset valid=%b cnt=%0d exp valid=1 cnt=%0d", wbif.wb_valid_o, ovr_cnt, exp_ovr);
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 0;
    checks++;
    if (wbif.wb_valid_o !== 1'b0 || pending !== '0 || ovr_cnt !== 32'd0 || ch_ready !== '0) begin
      failures++;
      $display("FAIL async_reset valid=%b pending=%b cnt=%0d ready=%b exp all 0",
               wbif.wb_valid_o, pending, ovr_cnt, ch_ready);
    end
    w0 = wr_count;
    step();
    rstn = 1'b1;
    wbif.wb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (wr_count != w0 || wbif.wb_valid_o !== 1'b0 || ch_ready !== {NUM_CH{1'b1}}) begin
      failures++;
      $display("FAIL post_reset writes=%0d valid=%b ready=%b exp writes=0 valid=0 ready=all1",
               wr_count - w0, wbif.wb_valid_o, ch_ready);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single();
    test_coalesce();
    test_multi_overwrite();
    test_backpressure();
    test_issue_capture();
    test_reset_in_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
